uart_rx_fifo: RTL and testbench
===============================

# uart_rx_fifo

Serial 8N1 UART receiver with an output FIFO. It consumes the serial stream produced by a processor's UART_Tx port (for example the TMP100 temperature read-out at 9600 baud) and presents each received byte on a valid/ready interface. It is the on-chip counterpart of a bench-side deserializer and is usable both as a loop-back checker and as a host-command input path.

## Interface
- G_CLK_DIVIDER, 10104 — clocks per bit (97 MHz / 9600 baud); legal range ≥ 8.
- G_FIFO_DEPTH, 16 — output FIFO entries; power of two, ≥ 2.
- i_clk  in  1  processor clock; all state on rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_uart_rx  in  1  serial input; idle high; asynchronous to i_clk.
- o_data  out  8  byte at FIFO head.
- o_valid  out  1  FIFO not empty.
- i_ready  in  1  consumer accepts o_data when o_valid && i_ready.
- o_frame_err  out  1  one-cycle pulse: stop bit sampled low.
- o_overflow  out  1  one-cycle pulse: completed byte dropped because the FIFO was full.
- o_busy  out  1  receiver FSM not in S_IDLE.

## Operation
- i_uart_rx passes through a 2-FF synchronizer, reset to 1. "rx" below means the synchronized value.
- Bit counter: 0..G_CLK_DIVIDER-1, cleared on every state entry. Sample point: count == G_CLK_DIVIDER-1, except S_START, which samples at count == G_CLK_DIVIDER/2-1 (integer divide).
- FSM states:
  - S_IDLE: on rx == 0, go to S_START.
  - S_START: at the half-bit sample, rx == 0 → S_DATA with bit index 0; rx == 1 → S_IDLE (glitch rejected, no error).
  - S_DATA: each full-bit sample shifts rx into bit [index], LSB first. After index 7, go to S_STOP.
  - S_STOP: at the full-bit sample, rx == 1 → push byte, go to S_IDLE. rx == 0 → pulse o_frame_err, discard byte, go to S_BREAK.
  - S_BREAK: wait for rx == 1, then S_IDLE. A break condition produces exactly one o_frame_err.
- FIFO push and pop:
  - Push when full and no pop in the same cycle → byte dropped, o_overflow pulses.
  - Push and pop in the same cycle while full → both take effect; no overflow.
  - Pop when empty is ignored.
- o_data is registered from the FIFO head. It is don't-care while o_valid == 0.

## Timing
- Reset values: o_data 8'h00, o_valid 0, o_frame_err 0, o_overflow 0, o_busy 0, FSM S_IDLE, FIFO empty, pointers 0, synchronizer 1.
- Reset asserted mid-frame aborts immediately. Any partial byte is lost and FIFO contents are lost.
- Latency, in i_clk cycles from the first i_clk edge that registers i_uart_rx low:
  - S_START entry: +2.
  - Stop sample: +2 + G_CLK_DIVIDER/2 + 9·G_CLK_DIVIDER.
  - FIFO write: one cycle after the stop sample.
  - o_valid high (empty case): the cycle after the FIFO write.
- o_frame_err and o_overflow each assert in the cycle after the stop sample.
- A new start bit is recognized from the first S_IDLE cycle. Back-to-back frames with a full-length stop bit are received without loss.
- Handshake: o_data and o_valid are stable while o_valid && !i_ready. Sustained throughput is one pop per cycle.

## Structure
- Package uart_rx_pkg holds:
  - the state enum (S_IDLE, S_START, S_DATA, S_STOP, S_BREAK);
  - localparam widths derived via $clog2 of G_CLK_DIVIDER and G_FIFO_DEPTH.
- Sub-module sync_fifo: parameterized width and depth, with full/empty flags and a registered read. It is instantiated once here and is reusable elsewhere.
- The top level contains the synchronizer, bit counter, FSM and shift register.

## Test plan
Use G_CLK_DIVIDER = 16 for simulation speed.
- Send 0xA5, then 0x3C back-to-back with i_ready = 1 → o_data 0xA5 then 0x3C, each o_valid asserted exactly at the computed latency; no error pulses.
- Send 0x55 with the stop bit driven low, then hold the line low for 40 bit times, then release → one o_frame_err pulse, no FIFO write, and the next 0x81 frame is received correctly.
- Drive a low glitch of 6 cycles (< 8) → FSM returns to S_IDLE; no write, no error.
- Hold i_ready = 0 and send 17 bytes 0x00..0x10 → o_overflow pulses once, on byte 0x10. Then drain → exactly 0x00..0x0F, in order.
- With the FIFO full, send a byte and assert i_ready exactly in its write cycle → no overflow; the new byte appears after the existing 15.
- Assert i_rst_n low in the middle of S_DATA, release, then send 0x7E → all outputs return to reset values and only 0x7E is received.

Source files
------------

// File: rtl/uart_rx_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | uart_rx_pkg : shared types and width helpers for the UART receiver |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package uart_rx_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } rx_state_t;

  localparam int C_DEF_CLK_DIVIDER = 10104;
  localparam int C_DEF_FIFO_DEPTH  = 16;
  localparam int C_BYTE_W          = 8;
  localparam int C_BIT_IDX_W       = $clog2(C_BYTE_W);

  function automatic int cnt_width(input int clk_divider);
    return $clog2(clk_divider);
  endfunction

  function automatic int ptr_width(input int depth);
    return $clog2(depth);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sync_fifo : single-clock FIFO with registered head and full/empty  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module sync_fifo
  import uart_rx_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = C_DEF_FIFO_DEPTH
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_rd_valid,
  output logic             o_full,
  output logic             o_empty
);

  localparam int PTR_W = ptr_width(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic [WIDTH-1:0] r_rd_data;
  logic             r_rd_valid;

  logic             w_pop;
  logic             w_push;
  logic [PTR_W-1:0] w_rd_next;
  logic [CNT_W-1:0] w_cnt_after_pop;

  assign o_full          = (r_count == CNT_W'(DEPTH));
  assign o_empty         = (r_count == '0);
  assign w_pop           = i_pop && r_rd_valid;
  assign w_push          = i_push && (!o_full || w_pop);
  assign w_rd_next       = r_rd_ptr + PTR_W'(w_pop);
  assign w_cnt_after_pop = r_count - CNT_W'(w_pop);

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  // The head register only sees entries written before this edge, so a
  // slot being written now can never be the one being presented.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_wr_ptr   <= r_wr_ptr + PTR_W'(w_push);
      r_rd_ptr   <= w_rd_next;
      r_count    <= w_cnt_after_pop + CNT_W'(w_push);
      r_rd_valid <= (w_cnt_after_pop != '0);
      r_rd_data  <= r_mem[w_rd_next];
    end
  end

  assign o_rd_data  = r_rd_data;
  assign o_rd_valid = r_rd_valid;

endmodule
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | uart_rx_fifo : 8N1 UART receiver feeding a valid/ready output FIFO |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module uart_rx_fifo
  import uart_rx_pkg::*;
#(
  parameter int G_CLK_DIVIDER = C_DEF_CLK_DIVIDER,
  parameter int G_FIFO_DEPTH  = C_DEF_FIFO_DEPTH
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_uart_rx,
  output logic [C_BYTE_W-1:0] o_data,
  output logic                o_valid,
  input  logic                i_ready,
  output logic                o_frame_err,
  output logic                o_overflow,
  output logic                o_busy
);

  localparam int               CNT_W         = cnt_width(G_CLK_DIVIDER);
  localparam logic [CNT_W-1:0] C_FULL_SAMPLE = CNT_W'(G_CLK_DIVIDER - 1);
  localparam logic [CNT_W-1:0] C_HALF_SAMPLE = CNT_W'(G_CLK_DIVIDER / 2 - 1);

  logic [1:0]             r_sync;
  rx_state_t              r_state;
  rx_state_t              w_state_next;
  logic [CNT_W-1:0]       r_cnt;
  logic [C_BIT_IDX_W-1:0] r_bit_idx;
  logic [C_BYTE_W-1:0]    r_shift;
  logic                   r_push;
  logic                   r_frame_err;

  logic w_rx;
  logic w_sample;
  logic w_shift_en;
  logic w_push;
  logic w_frame_err;
  logic w_full;
  logic w_empty;
  logic w_pop;

  assign w_rx     = r_sync[1];
  assign w_sample = (r_state == S_START) ? (r_cnt == C_HALF_SAMPLE)
                                         : (r_cnt == C_FULL_SAMPLE);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= 2'b11;
    end else begin
      r_sync <= {r_sync[0], i_uart_rx};
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_shift_en   = 1'b0;
    w_push       = 1'b0;
    w_frame_err  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (!w_rx) w_state_next = S_START;
      end
      S_START: begin
        if (w_sample) w_state_next = w_rx ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        if (w_sample) begin
          w_shift_en = 1'b1;
          if (r_bit_idx == C_BIT_IDX_W'(C_BYTE_W - 1)) w_state_next = S_STOP;
        end
      end
      S_STOP: begin
        if (w_sample) begin
          if (w_rx) begin
            w_push       = 1'b1;
            w_state_next = S_IDLE;
          end else begin
            w_frame_err  = 1'b1;
            w_state_next = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        if (w_rx) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Counter restarts on every state change and after each sample point.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt       <= '0;
      r_bit_idx   <= '0;
      r_shift     <= '0;
      r_push      <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      if ((w_state_next != r_state) || w_sample) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (r_state != S_DATA) begin
        r_bit_idx <= '0;
      end else if (w_shift_en) begin
        r_bit_idx <= r_bit_idx + C_BIT_IDX_W'(1);
      end
      if (w_shift_en) begin
        r_shift[r_bit_idx] <= w_rx;
      end
      r_push      <= w_push;
      r_frame_err <= w_frame_err;
    end
  end

  // A push into a full FIFO survives only if the consumer pops in the same cycle.
  assign w_pop       = i_ready && o_valid && !w_empty;
  assign o_overflow  = r_push && w_full && !w_pop;
  assign o_frame_err = r_frame_err;
  assign o_busy      = (r_state != S_IDLE);

  sync_fifo #(
    .WIDTH (C_BYTE_W),
    .DEPTH (G_FIFO_DEPTH)
  ) u_fifo (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_push      (r_push),
    .i_push_data (r_shift),
    .i_pop       (w_pop),
    .o_rd_data   (o_data),
    .o_rd_valid  (o_valid),
    .o_full      (w_full),
    .o_empty     (w_empty)
  );

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_uart_rx_fifo : self-checking bench for uart_rx_fifo             |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_uart_rx_fifo;

  localparam int D     = 16;
  localparam int DEPTH = 16;
  // Cycles from the cycle a start bit is driven to the error/overflow pulse
  // (stop sample edge) and to the first cycle o_valid is high.
  localparam int LAT_PULSE = 1 + 2 + D / 2 + 9 * D;
  localparam int LAT_VALID = LAT_PULSE + 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx;
  logic       ready;
  logic [7:0] data;
  logic       valid, ferr, ovf, busy;

  uart_rx_fifo #(
    .G_CLK_DIVIDER (D),
    .G_FIFO_DEPTH  (DEPTH)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_uart_rx   (rx),
    .o_data      (data),
    .o_valid     (valid),
    .i_ready     (ready),
    .o_frame_err (ferr),
    .o_overflow  (ovf),
    .o_busy      (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   rx_q[$];
  int   pop_cyc_q[$];
  int   rise_q[$];
  int   ferr_q[$];
  int   ovf_q[$];
  int   busy_cycles = 0;
  int   stab_err = 0;
  logic prev_valid = 1'b0;
  logic prev_ready = 1'b0;
  logic [7:0] prev_data = 8'h00;

  always @(negedge clk) begin
    if (valid && ready) begin
      rx_q.push_back(int'(data));
      pop_cyc_q.push_back(cyc);
    end
    if (valid && !prev_valid) rise_q.push_back(cyc);
    if (ferr) ferr_q.push_back(cyc);
    if (ovf) ovf_q.push_back(cyc);
    if (busy) busy_cycles <= busy_cycles + 1;
    if (rst_n && prev_valid && !prev_ready && (!valid || data != prev_data))
      stab_err <= stab_err + 1;
    prev_valid <= valid;
    prev_ready <= ready;
    prev_data  <= data;
  end

  int n_pass = 0;
  int n_tot  = 0;

  task automatic check(input string name, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  function automatic int qat(ref int q[$], input int idx);
    return (idx < q.size()) ? q[idx] : -1;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Caller is one time unit after a rising edge; k is the start-bit cycle.
  task automatic send_frame(input logic [7:0] b, input bit stop_hi, output int k);
    k  = cyc;
    rx = 1'b0;
    tick(D);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(D);
    end
    rx = stop_hi;
    tick(D);
    rx = 1'b1;
  endtask

  typedef struct {
    logic [7:0] data;
    bit         stop_hi;
    int         low_hold;
    int         gap;
    bit         exp_byte;
  } vec_t;

  vec_t       vecs[6];
  int         exp_bytes[$];
  int         exp_rise[$];
  int         exp_ferr[$];
  int         rb, fb, ob, pb, qb, bb, k, kk;
  int         model_q[$];
  logic [7:0] rb_byte;
  bit         done;

  initial begin
    vecs[0] = '{8'hA5, 1'b1, 0,      0,  1'b1};
    vecs[1] = '{8'h3C, 1'b1, 0,      40, 1'b1};
    vecs[2] = '{8'h55, 1'b0, 40 * D, 40, 1'b0};
    vecs[3] = '{8'h81, 1'b1, 0,      40, 1'b1};
    vecs[4] = '{8'h00, 1'b1, 0,      0,  1'b1};
    vecs[5] = '{8'hFF, 1'b1, 0,      40, 1'b1};

    rst_n = 1'b0; rx = 1'b1; ready = 1'b0;
    tick(3);
    check("reset_valid", int'(valid), 0);
    check("reset_data", int'(data), 0);
    check("reset_ferr", int'(ferr), 0);
    check("reset_ovf", int'(ovf), 0);
    check("reset_busy", int'(busy), 0);
    rst_n = 1'b1;
    tick(5);

    // Table-driven frames, consumer always ready.
    ready = 1'b1;
    rb = rx_q.size(); fb = ferr_q.size(); ob = ovf_q.size(); qb = rise_q.size();
    foreach (vecs[i]) begin
      send_frame(vecs[i].data, vecs[i].stop_hi, k);
      if (vecs[i].exp_byte) begin
        exp_bytes.push_back(int'(vecs[i].data));
        exp_rise.push_back(k + LAT_VALID);
      end
      if (!vecs[i].stop_hi) exp_ferr.push_back(k + LAT_PULSE);
      if (vecs[i].low_hold > 0) begin
        rx = 1'b0;
        tick(vecs[i].low_hold);
        rx = 1'b1;
      end
      if (vecs[i].gap > 0) tick(vecs[i].gap);
    end
    tick(200);
    check("tbl_count", rx_q.size() - rb, exp_bytes.size());
    foreach (exp_bytes[i]) begin
      check($sformatf("tbl_byte%0d", i), qat(rx_q, rb + i), exp_bytes[i]);
      check($sformatf("tbl_valid_rise%0d", i), qat(rise_q, qb + i), exp_rise[i]);
    end
    check("tbl_ferr_count", ferr_q.size() - fb, exp_ferr.size());
    foreach (exp_ferr[i]) check($sformatf("tbl_ferr_cyc%0d", i), qat(ferr_q, fb + i), exp_ferr[i]);
    check("tbl_ovf_count", ovf_q.size() - ob, 0);

    // Short low glitch: START for half a bit, then back to idle.
    rb = rx_q.size(); fb = ferr_q.size(); bb = busy_cycles;
    rx = 1'b0;
    tick(6);
    rx = 1'b1;
    tick(30);
    check("glitch_busy_cycles", busy_cycles - bb, D / 2);
    check("glitch_no_byte", rx_q.size() - rb, 0);
    check("glitch_no_ferr", ferr_q.size() - fb, 0);
    check("glitch_idle", int'(busy), 0);

    // Seventeen bytes into a stalled FIFO: the last is dropped.
    ready = 1'b0;
    rb = rx_q.size(); ob = ovf_q.size(); pb = pop_cyc_q.size();
    for (int b = 0; b <= 16; b++) send_frame(8'(b), 1'b1, k);
    tick(20);
    check("ovf_count", ovf_q.size() - ob, 1);
    check("ovf_cyc", qat(ovf_q, ob), k + LAT_PULSE);
    check("ovf_valid_held", int'(valid), 1);
    ready = 1'b1;
    tick(30);
    ready = 1'b0;
    check("ovf_drain_count", rx_q.size() - rb, 16);
    for (int i = 0; i < 16; i++) check($sformatf("ovf_drain%0d", i), qat(rx_q, rb + i), i);
    check("drain_rate", qat(pop_cyc_q, pb + 15) - qat(pop_cyc_q, pb), 15);

    // Full FIFO with a pop in the exact write cycle of a new byte.
    rb = rx_q.size(); ob = ovf_q.size();
    for (int b = 0; b < 16; b++) send_frame(8'(8'h20 + b), 1'b1, k);
    tick(20);
    kk = cyc;
    fork
      send_frame(8'h30, 1'b1, k);
      begin
        tick(LAT_PULSE);
        ready = 1'b1;
        tick(1);
        ready = 1'b0;
      end
    join
    tick(10);
    check("full_pop_no_ovf", ovf_q.size() - ob, 0);
    check("full_pop_one", rx_q.size() - rb, 1);
    ready = 1'b1;
    tick(30);
    ready = 1'b0;
    check("full_pop_total", rx_q.size() - rb, 17);
    for (int i = 0; i < 17; i++) check($sformatf("full_order%0d", i), qat(rx_q, rb + i), 8'h20 + i);

    // Reset in the middle of S_DATA with a byte already buffered.
    send_frame(8'h11, 1'b1, k);
    tick(5);
    check("pre_rst_valid", int'(valid), 1);
    rx = 1'b0; tick(D);
    rx = 1'b1; tick(D);
    rx = 1'b0; tick(D / 2);
    check("pre_rst_busy", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    check("rst_valid", int'(valid), 0);
    check("rst_data", int'(data), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_ferr", int'(ferr), 0);
    check("rst_ovf", int'(ovf), 0);
    rx = 1'b1;
    tick(3);
    rst_n = 1'b1;
    tick(5);
    rb = rx_q.size(); fb = ferr_q.size();
    ready = 1'b1;
    send_frame(8'h7E, 1'b1, k);
    tick(30);
    check("post_rst_count", rx_q.size() - rb, 1);
    check("post_rst_byte", qat(rx_q, rb), 8'h7E);
    check("post_rst_no_ferr", ferr_q.size() - fb, 0);

    // Random bytes, random gaps, random rejected glitches, random consumer.
    rb = rx_q.size(); fb = ferr_q.size(); ob = ovf_q.size();
    done = 1'b0;
    fork
      begin
        for (int n = 0; n < 24; n++) begin
          if ($urandom_range(0, 3) == 0) begin
            rx = 1'b0;
            tick($urandom_range(1, 7));
            rx = 1'b1;
            tick(12);
          end
          rb_byte = 8'($urandom);
          send_frame(rb_byte, 1'b1, k);
          model_q.push_back(int'(rb_byte));
          if ($urandom_range(0, 1) == 1) tick($urandom_range(1, 30));
        end
        tick(200);
        done = 1'b1;
      end
      begin
        while (!done) begin
          ready = 1'($urandom_range(0, 1));
          tick(1);
        end
      end
    join
    ready = 1'b1;
    tick(20);
    ready = 1'b0;
    check("rand_count", rx_q.size() - rb, model_q.size());
    foreach (model_q[i]) check($sformatf("rand_byte%0d", i), qat(rx_q, rb + i), model_q[i]);
    check("rand_no_ferr", ferr_q.size() - fb, 0);
    check("rand_no_ovf", ovf_q.size() - ob, 0);
    check("handshake_stable", stab_err, 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
`default_nettype wire
